ultrasonic_scan_controller: RTL and testbench

Round-robin scheduler for a bank of HC-SR04-style ultrasonic rangers on the mower. It drives one sensor at a time, so only one transducer is active and there is no acoustic crosstalk. For each sensor it issues the trigger pulse, times the echo pulse in microseconds with a shared internal tick prescaler, and reports one result per sensor. A settle gap separates consecutive sensors.

---
 rtl/ultrasonic_scan_controller.sv | 186 ++++++++++++++++++
 tb/tb_ultrasonic_scan_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_scan_controller.sv
// Round-robin HC-SR04 ranger scheduler: one sensor at a time,
// trigger, time the echo in microseconds, report, then settle.
module ultrasonic_scan_controller #(
  parameter int NUM_SENSORS = 4,
  parameter int CLK_PER_US  = 100,
  parameter int TRIG_US     = 10,
  parameter int TIMEOUT_US  = 30000,
  parameter int GAP_US      = 10000,
  localparam int IDW = (NUM_SENSORS > 1) ?
                       $clog2(NUM_SENSORS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trig,
  output logic [15:0]            dist_us,
  output logic [IDW-1:0]         dist_id,
  output logic                   dist_valid,
  output logic                   dist_timeout,
  output logic                   busy
);

  localparam int PW = (CLK_PER_US > 1) ?
                      $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_US - 1);
  localparam logic [15:0] TMO      = 16'(TIMEOUT_US);
  localparam logic [15:0] TRIG_END = 16'(TRIG_US - 1);
  localparam logic [15:0] TMO_END  = 16'(TIMEOUT_US - 1);
  localparam logic [15:0] GAP_END  = 16'(GAP_US - 1);
  localparam logic [IDW-1:0] SEL_MAX = IDW'(NUM_SENSORS - 1);
  localparam logic [NUM_SENSORS-1:0] ONE = NUM_SENSORS'(1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GAP
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_SENSORS-1:0] echo_m_q, echo_s_q;
  logic [PW-1:0]          pre_q, pre_d;
  logic [15:0]            us_q, us_d, us_nxt;
  logic [IDW-1:0]         sel_q, sel_d, sel_inc;
  logic [NUM_SENSORS-1:0] trig_q, trig_d;
  logic [15:0]            dist_us_q, dist_us_d;
  logic [IDW-1:0]         dist_id_q, dist_id_d;
  logic                   dist_valid_q, dist_valid_d;
  logic                   dist_to_q, dist_to_d;
  logic                   busy_q, busy_d;
  logic                   tick, echo_sel, go;

  assign tick     = (pre_q == PRE_MAX);
  assign echo_sel = echo_s_q[sel_q];
  assign sel_inc  = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;

  // Counter sits at TIMEOUT_US once reached
  always_comb begin
    us_nxt = us_q;
    if (tick && us_q != TMO) us_nxt = us_q + 16'd1;
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    pre_d        = tick ? '0 : pre_q + 1'b1;
    us_d         = us_nxt;
    trig_d       = trig_q;
    dist_us_d    = dist_us_q;
    dist_id_d    = dist_id_q;
    dist_valid_d = 1'b0;
    dist_to_d    = dist_to_q;
    busy_d       = busy_q;
    go           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = TRIG;
          trig_d  = ONE << sel_q;
          busy_d  = 1'b1;
          go      = 1'b1;
        end
      end
      TRIG: begin
        if (tick && us_q == TRIG_END) begin
          state_d = WAIT_RISE;
          trig_d  = '0;
          go      = 1'b1;
        end
      end
      WAIT_RISE: begin
        if (tick && us_q == TMO_END) begin
          state_d      = GAP;
          dist_us_d    = TMO;
          dist_id_d    = sel_q;
          dist_to_d    = 1'b1;
          dist_valid_d = 1'b1;
          go           = 1'b1;
        end else if (echo_sel) begin
          state_d = MEASURE;
          go      = 1'b1;
        end
      end
      MEASURE: begin
        if (!echo_sel) begin
          state_d      = GAP;
          dist_us_d    = us_nxt;
          dist_id_d    = sel_q;
          dist_to_d    = 1'b0;
          dist_valid_d = 1'b1;
          go           = 1'b1;
        end else if (tick && us_q == TMO_END) begin
          state_d      = GAP;
          dist_us_d    = TMO;
          dist_id_d    = sel_q;
          dist_to_d    = 1'b1;
          dist_valid_d = 1'b1;
          go           = 1'b1;
        end
      end
      GAP: begin
        if (tick && us_q == GAP_END) begin
          sel_d = sel_inc;
          go    = 1'b1;
          if (enable) begin
            state_d = TRIG;
            trig_d  = ONE << sel_inc;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        trig_d  = '0;
        busy_d  = 1'b0;
        go      = 1'b1;
      end
    endcase
    if (go) begin
      pre_d = '0;
      us_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      echo_m_q     <= '0;
      echo_s_q     <= '0;
      pre_q        <= '0;
      us_q         <= '0;
      sel_q        <= '0;
      trig_q       <= '0;
      dist_us_q    <= '0;
      dist_id_q    <= '0;
      dist_valid_q <= 1'b0;
      dist_to_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      echo_m_q     <= echo;
      echo_s_q     <= echo_m_q;
      pre_q        <= pre_d;
      us_q         <= us_d;
      sel_q        <= sel_d;
      trig_q       <= trig_d;
      dist_us_q    <= dist_us_d;
      dist_id_q    <= dist_id_d;
      dist_valid_q <= dist_valid_d;
      dist_to_q    <= dist_to_d;
      busy_q       <= busy_d;
    end
  end

  assign trig         = trig_q;
  assign dist_us      = dist_us_q;
  assign dist_id      = dist_id_q;
  assign dist_valid   = dist_valid_q;
  assign dist_timeout = dist_to_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ultrasonic_scan_controller.sv
// Scoreboard bench for ultrasonic_scan_controller with a
// cycle-level reference model of echo timing.
module tb_ultrasonic_scan_controller;

  localparam int N    = 3;
  localparam int CPU  = 4;
  localparam int TRG  = 2;
  localparam int TMO  = 20;
  localparam int GAPU = 3;
  localparam int TRIG_CYC = TRG * CPU;
  localparam int TMO_CYC  = TMO * CPU;
  localparam int GAP_CYC  = GAPU * CPU;
  localparam int SYNC     = 2;

  typedef struct {
    int id;
    int us;
    int to;
    int cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] echo;
  logic [N-1:0] trig;
  logic [15:0]  dist_us;
  logic [1:0]   dist_id;
  logic         dist_valid;
  logic         dist_timeout;
  logic         busy;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_valid = -1000;
  int   exp_sel = 0;
  int   rise_at = -1;
  bit   gap_chk = 1'b0;
  exp_t sbq[$];

  ultrasonic_scan_controller #(
    .NUM_SENSORS(N),
    .CLK_PER_US(CPU),
    .TRIG_US(TRG),
    .TIMEOUT_US(TMO),
    .GAP_US(GAPU)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .echo(echo),
    .trig(trig),
    .dist_us(dist_us),
    .dist_id(dist_id),
    .dist_valid(dist_valid),
    .dist_timeout(dist_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, req);
    end
  endtask

  // Echo seen SYNC cycles after the drive; it must beat the
  // WAIT_RISE timeout decision made in cycle TMO_CYC-1.
  function automatic exp_t model(int id, int d, int w, int f);
    exp_t e;
    e.id = id;
    if (w == 0 || d + SYNC >= TMO_CYC - 1) begin
      e.us = TMO; e.to = 1; e.cyc = f + TMO_CYC;
    end else if (w <= TMO_CYC) begin
      e.us = w / CPU; e.to = 0; e.cyc = f + d + SYNC + w + 1;
    end else begin
      e.us = TMO; e.to = 1; e.cyc = f + d + SYNC + 1 + TMO_CYC;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (trig != '0) chk("trig_onehot", $countones(trig), 1);
    if (dist_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("dist_id", dist_id, e.id);
        chk("dist_us", dist_us, e.us);
        chk("dist_timeout", dist_timeout, e.to);
        chk("valid_cycle", cyc, e.cyc);
      end
      last_valid = cyc;
    end
  end

  task automatic pulse(input int i, input int d, input int w);
    repeat (d) @(negedge clk);
    echo[i] = 1'b1;
    repeat (w) @(negedge clk);
    echo[i] = 1'b0;
  endtask

  task automatic run_slot(input int d, input int w,
                          input bit drop, input bit abort);
    int n;
    int f;
    int ps, nj, nd, nw;
    n = 0;
    while (trig == '0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (trig == '0) begin
      chk("trig_rise_bound", 0, 1);
      return;
    end
    if (rise_at >= 0) chk("rise_cycle", cyc, rise_at);
    rise_at = -1;
    if (gap_chk) chk("gap_len", cyc - last_valid, GAP_CYC);
    chk("trig_sel", trig, 1 << exp_sel);
    if (drop) enable = 1'b0;
    n = 0;
    while (trig != '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("trig_width", n, TRIG_CYC);
    f = cyc;
    if (!abort) sbq.push_back(model(exp_sel, d, w, f));
    ps = exp_sel;
    nj = (exp_sel + 1 + $urandom_range(0, N - 2)) % N;
    nd = $urandom_range(0, 10);
    nw = $urandom_range(1, 10);
    if (w > 0) fork pulse(ps, d, w); join_none
    fork pulse(nj, nd, nw); join_none
    exp_sel = (exp_sel + 1) % N;
    gap_chk = !drop && !abort;
  endtask

  task automatic rand_slot();
    int d, w;
    d = $urandom_range(0, 80);
    w = (d > 70) ? $urandom_range(0, 40) : $urandom_range(0, 90);
    run_slot(d, w, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drain", sbq.size(), 0);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    echo   = '1;
    repeat (4) @(negedge clk);
    chk("rst_trig", trig, 0);
    chk("rst_dist_us", dist_us, 0);
    chk("rst_dist_id", dist_id, 0);
    chk("rst_valid", dist_valid, 0);
    chk("rst_timeout", dist_timeout, 0);
    chk("rst_busy", busy, 0);
    echo  = '0;
    reset = 1'b0;
    rise_at = cyc + 1;

    run_slot(5, 40, 1'b0, 1'b0);
    run_slot(3, 200, 1'b0, 1'b0);
    run_slot(0, 0, 1'b0, 1'b0);
    run_slot(0, 0, 1'b0, 1'b0);
    run_slot(76, 80, 1'b0, 1'b0);
    run_slot(77, 10, 1'b0, 1'b0);
    run_slot(0, 81, 1'b0, 1'b0);
    run_slot(10, 3, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) rand_slot();

    while (exp_sel != 1) rand_slot();
    run_slot(3, 30, 1'b0, 1'b1);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_trig", trig, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", dist_valid, 0);
    repeat (2) @(negedge clk);
    chk("abort_sb", sbq.size(), 0);
    reset   = 1'b0;
    exp_sel = 0;
    gap_chk = 1'b0;
    rise_at = cyc + 1;
    for (int k = 0; k < 3; k++) rand_slot();

    while (exp_sel != 1) rand_slot();
    run_slot(5, 40, 1'b1, 1'b0);
    drain();
    while (cyc < last_valid + GAP_CYC - 1) @(negedge clk);
    chk("busy_in_gap", busy, 1);
    @(negedge clk);
    chk("busy_after_gap", busy, 0);
    repeat (20) @(negedge clk);
    chk("idle_trig", trig, 0);
    chk("idle_busy", busy, 0);
    chk("hold_dist_us", dist_us, 10);
    chk("hold_dist_id", dist_id, 1);
    enable  = 1'b1;
    rise_at = cyc + 1;
    rand_slot();
    rand_slot();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
